// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD character path.
//   stream_state_t : stream engine states (IDLE / RUN / DRAIN)
//   CHAR_W         : character width (ASCII byte)
//   ROW_LEN, ROW1_BASE, ROW2_BASE : 2x16 display geometry, used by callers
//                    to form start_addr / count for one display row
package lcd_pkg;

   localparam int CHAR_W    = 8;

   localparam int ROW_LEN   = 16;
   localparam int ROW1_BASE = 0;
   localparam int ROW2_BASE = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stream_state_t;

endpackage

// File: rtl/lcd_sdp_ram.sv
// Simple-dual-port inferred RAM: one write port, one registered read port.
// Optional even-parity bit stored alongside each word (PAR_EN = 1); the raw
// stored word, parity included, is returned so the reader can check it.
// Ports:
//   clk                       clock, rising edge
//   wr_en, wr_addr, wr_data   write port, lands on the edge where wr_en = 1
//   rd_en, rd_addr            read request, data valid the following cycle
//   rd_word                   registered read word {parity, data} / {data}
// WRITE_FIRST = 0 returns old data on a same-address collision, 1 returns
// the word being written.
module lcd_sdp_ram
   import lcd_pkg::*;
#(
   parameter int DATA_W      = CHAR_W,
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int WRITE_FIRST = 0,
   parameter int PAR_EN      = 0
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic [DATA_W+PAR_EN-1:0]   rd_word
);

   localparam int MEM_W = DATA_W + PAR_EN;

   logic [MEM_W-1:0] mem [DEPTH];
   logic [MEM_W-1:0] wr_word;
   logic [MEM_W-1:0] rd_q;

   generate
      if (PAR_EN != 0) begin : g_par
         // even parity: the stored word always holds an even number of ones
         assign wr_word = {^wr_data, wr_data};
      end else begin : g_nopar
         assign wr_word = wr_data;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_word;
      end
      if (rd_en) begin
         if ((WRITE_FIRST != 0) && wr_en && (wr_addr == rd_addr)) begin
            rd_q <= wr_word;
         end else begin
            rd_q <= mem[rd_addr];
         end
      end
   end

   assign rd_word = rd_q;

endmodule

// File: rtl/lcd_char_stream_buf.sv
// Character buffer for the LCD driver: host-writable SDP RAM plus a stream
// engine that walks [start_addr, start_addr+count) modulo DEPTH and hands
// characters to the LCD command/data FSM over valid/ready.
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   wr_en, wr_addr, wr_data       host write port, always accepted
//   start, start_addr, count      launch a stream (count 0..DEPTH)
//   abort                         cancel the current stream
//   busy, done                    stream in progress / end-of-stream pulse
//   out_valid, out_ready,
//   out_data, out_last            character stream, last marks beat #count
// Optional build macro LCD_CHAR_BUF_PARITY_EN adds stored parity and
//   par_err    (pulse with the transfer of a beat that failed parity)
//   err_sticky (set on any parity error, cleared only by reset)
//
// state | meaning
// IDLE  | no stream; waiting for start
// RUN   | issuing RAM reads while characters remain
// DRAIN | all reads issued; waiting for the output FIFO to empty
module lcd_char_stream_buf
   import lcd_pkg::*;
#(
   parameter int DATA_W      = CHAR_W,
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int WRITE_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
`ifdef LCD_CHAR_BUF_PARITY_EN
   ,
   output logic              par_err,
   output logic              err_sticky
`endif
);

`ifdef LCD_CHAR_BUF_PARITY_EN
   localparam int PAR_EN = 1;
   localparam int ENT_W  = DATA_W + 2;   // {perr, last, data}
`else
   localparam int PAR_EN = 0;
   localparam int ENT_W  = DATA_W + 1;   // {last, data}
`endif

   localparam logic [ADDR_W:0] CNT_ZERO = '0;
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   stream_state_t state, state_nx;

   logic [ADDR_W-1:0] rd_ptr, rd_ptr_nx;
   logic [ADDR_W:0]   remaining, remaining_nx;
   logic              done_nx;

   logic              issue;
   logic              issue_last;
   logic [ADDR_W-1:0] issue_addr;
   logic              inflight;
   logic              inflight_last;

   logic [1:0]        fifo_cnt;
   logic [ENT_W-1:0]  slot0, slot1;
   logic [ENT_W-1:0]  ent_in;
   logic              push, pop, flush, room;

   logic [DATA_W+PAR_EN-1:0] ram_word;

   lcd_sdp_ram #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .WRITE_FIRST (WRITE_FIRST),
      .PAR_EN      (PAR_EN)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (issue),
      .rd_addr (issue_addr),
      .rd_word (ram_word)
   );

`ifdef LCD_CHAR_BUF_PARITY_EN
   assign ent_in = {^ram_word, inflight_last, ram_word[DATA_W-1:0]};
`else
   assign ent_in = {inflight_last, ram_word};
`endif

   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = slot0[DATA_W-1:0];
   assign out_last  = slot0[DATA_W];
   assign pop       = out_valid && out_ready;
   assign push      = inflight && !flush;
   assign busy      = (state != IDLE);

   // Room is judged on FIFO entries plus the read in flight; a pop in the
   // same cycle frees a slot, which keeps one character per cycle flowing.
   assign room = ((fifo_cnt + {1'b0, inflight}) < 2'd2) || pop;

   always_comb begin
      state_nx     = state;
      rd_ptr_nx    = rd_ptr;
      remaining_nx = remaining;
      done_nx      = 1'b0;
      issue        = 1'b0;
      issue_last   = 1'b0;
      issue_addr   = rd_ptr;
      flush        = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (count == CNT_ZERO) begin
                  done_nx = 1'b1;
               end else begin
                  // first read goes out in the start cycle itself
                  issue        = 1'b1;
                  issue_addr   = start_addr;
                  issue_last   = (count == CNT_ONE);
                  rd_ptr_nx    = start_addr + 1'b1;
                  remaining_nx = count - 1'b1;
                  state_nx     = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               flush    = 1'b1;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else if (remaining == CNT_ZERO) begin
               state_nx = DRAIN;
            end else if (room) begin
               issue        = 1'b1;
               issue_last   = (remaining == CNT_ONE);
               rd_ptr_nx    = rd_ptr + 1'b1;
               remaining_nx = remaining - 1'b1;
            end
         end
         DRAIN: begin
            if (abort) begin
               flush    = 1'b1;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else if (!inflight &&
                         ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rd_ptr        <= '0;
         remaining     <= '0;
         done          <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_nx;
         rd_ptr        <= rd_ptr_nx;
         remaining     <= remaining_nx;
         done          <= done_nx;
         inflight      <= issue;
         inflight_last <= issue_last;
      end
   end

   // 2-entry FIFO, slot0 is the head; slot0 only changes on a pop or a push
   // into an empty FIFO, so the head stays put while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_cnt <= 2'd0;
         slot0    <= '0;
         slot1    <= '0;
      end else if (flush) begin
         fifo_cnt <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fifo_cnt == 2'd0) begin
                  slot0 <= ent_in;
               end else begin
                  slot1 <= ent_in;
               end
               fifo_cnt <= fifo_cnt + 2'd1;
            end
            2'b01: begin
               slot0    <= slot1;
               fifo_cnt <= fifo_cnt - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt == 2'd1) begin
                  slot0 <= ent_in;
               end else begin
                  slot0 <= slot1;
                  slot1 <= ent_in;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LCD_CHAR_BUF_PARITY_EN
   assign par_err = pop && slot0[DATA_W+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (par_err) begin
         err_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_lcd_char_stream_buf.sv
module tb_lcd_char_stream_buf;
   import lcd_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int WF     = 0;

   logic              clk, rst_n;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   count;
   logic              abort;
   logic              busy, done, out_valid, out_ready, out_last;
   logic [DATA_W-1:0] out_data;
`ifdef LCD_CHAR_BUF_PARITY_EN
   logic              par_err, err_sticky;
`endif

   lcd_char_stream_buf #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .WRITE_FIRST(WF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .start_addr(start_addr), .count(count), .abort(abort),
      .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
`ifdef LCD_CHAR_BUF_PARITY_EN
      , .par_err(par_err), .err_sticky(err_sticky)
`endif
   );

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              perr;
   } exp_t;

   exp_t              q[$];
   logic [DATA_W-1:0] model [DEPTH];
   int                checks, errors, beats, cyc, last_cyc, s_cyc, dcyc, b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: the head of q must be shown while valid, and pops on transfer
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: observed data %0h expected no beat", out_data);
         end
         if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_last", out_last, q[0].last);
`ifdef LCD_CHAR_BUF_PARITY_EN
            if (out_ready) chk("par_err", par_err, q[0].perr);
`endif
            if (out_ready) begin
               void'(q.pop_front());
               beats++;
               if (out_last) last_cyc = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      model[a] = d;
   endtask

   task automatic expect_stream(input logic [ADDR_W-1:0] sa, input int n);
      for (int i = 0; i < n; i++) begin
         logic [ADDR_W-1:0] idx;
         exp_t e;
         idx    = sa + ADDR_W'(i);
         e.data = model[idx];
         e.last = (i == n - 1);
         e.perr = 1'b0;
         q.push_back(e);
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] sa, input int n);
      start = 1'b1; start_addr = sa; count = (ADDR_W+1)'(n);
      s_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input bit toggle, input bit stray, output int dc);
      logic [3:0] pat;
      pat = 4'b1001;
      dc  = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin
            dc = cyc;
            break;
         end
         tick();
         if (toggle) out_ready = pat[i % 4];
         start      = stray && (i == 4);
         start_addr = 6'd40;
         if (stray && i == 4) count = 7'd3;
      end
      start = 1'b0;
      chk("done_seen", (dc >= 0), 1);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; start_addr = '0; count = '0; abort = 1'b0; out_ready = 1'b1;
      checks = 0; errors = 0; beats = 0; cyc = 0; last_cyc = 0;
      #2;
      chk("reset_outputs", {busy, done, out_valid, out_last, out_data}, 0);
`ifdef LCD_CHAR_BUF_PARITY_EN
      chk("reset_sticky", err_sticky, 0);
`endif
      tick(); tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < ROW_LEN; i++) wr(ADDR_W'(i), 8'h41 + DATA_W'(i));

      // full row, consumer always ready
      expect_stream(ROW1_BASE, ROW_LEN);
      pulse_start(ROW1_BASE, ROW_LEN);
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      chk("no_valid_cycle1", out_valid, 0);
      tick();
      @(negedge clk);
      chk("first_valid_cycle2", out_valid, 1);
      wait_done(1'b0, 1'b0, dcyc);
      chk("done_after_last", dcyc, last_cyc + 1);
      chk("busy_low_with_done", busy, 0);
      chk("row_throughput", last_cyc - s_cyc, 17);
      chk("row_all_beats", q.size(), 0);
      tick();
      @(negedge clk);
      chk("done_one_cycle", done, 0);

      // stalling consumer plus a start while busy that must be ignored
      tick();
      expect_stream(0, 16);
      pulse_start(0, 16);
      wait_done(1'b1, 1'b1, dcyc);
      chk("stall_all_beats", q.size(), 0);
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("stray_start_ignored", {busy, out_valid}, 0);

      // wrap DEPTH-1 -> 0
      tick();
      wr(6'd62, 8'h61);
      wr(6'd63, 8'h62);
      expect_stream(6'd62, 4);
      pulse_start(6'd62, 4);
      wait_done(1'b0, 1'b0, dcyc);
      chk("wrap_all_beats", q.size(), 0);

      // read/write collision on address 5
      tick();
      begin
         exp_t e;
         e.data = (WF != 0) ? 8'h7C : model[5];
         e.last = 1'b1;
         e.perr = 1'b0;
         q.push_back(e);
      end
      start = 1'b1; start_addr = 6'd5; count = 7'd1;
      wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h7C;
      tick();
      start = 1'b0; wr_en = 1'b0;
      model[5] = 8'h7C;
      wait_done(1'b0, 1'b0, dcyc);
      chk("collision_beats", q.size(), 0);
      tick();
      expect_stream(6'd5, 1);
      pulse_start(6'd5, 1);
      wait_done(1'b0, 1'b0, dcyc);
      chk("write_landed", q.size(), 0);
      tick();
      wr(6'd5, 8'h46);

      // zero-length stream
      start = 1'b1; start_addr = '0; count = '0;
      @(negedge clk);
      chk("zero_busy_c0", busy, 0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("zero_done", {done, busy, out_valid}, 3'b100);
      tick();
      @(negedge clk);
      chk("zero_after", {done, busy, out_valid}, 3'b000);

      // abort after 3 beats, with a simultaneous start
      tick();
      b0 = beats;
      expect_stream(0, 16);
      pulse_start(0, 16);
      for (int i = 0; i < 50; i++) begin
         if (beats - b0 >= 3) break;
         tick();
      end
      out_ready = 1'b0;
      abort = 1'b1; start = 1'b1; start_addr = 6'd10; count = 7'd5;
      tick();
      abort = 1'b0; start = 1'b0;
      q.delete();
      @(negedge clk);
      chk("abort_beats", beats - b0, 3);
      chk("abort_done", {done, busy, out_valid}, 3'b100);
      tick();
      @(negedge clk);
      chk("abort_start_ignored", {done, busy, out_valid}, 3'b000);
      out_ready = 1'b1;
      tick();
      expect_stream(6'd2, 4);
      pulse_start(6'd2, 4);
      wait_done(1'b0, 1'b0, dcyc);
      chk("post_abort_stream", q.size(), 0);

      // reset mid-stream, then memory must still hold the text
      tick();
      expect_stream(0, 16);
      pulse_start(0, 16);
      tick(); tick(); tick(); tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {busy, done, out_valid, out_last, out_data}, 0);
      q.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      expect_stream(0, 16);
      pulse_start(0, 16);
      wait_done(1'b0, 1'b0, dcyc);
      chk("memory_retained", q.size(), 0);

`ifdef LCD_CHAR_BUF_PARITY_EN
      tick();
      chk("sticky_clear", err_sticky, 0);
      dut.u_ram.mem[3][DATA_W] = ~dut.u_ram.mem[3][DATA_W];
      begin
         exp_t e;
         e.data = model[3];
         e.last = 1'b1;
         e.perr = 1'b1;
         q.push_back(e);
      end
      pulse_start(6'd3, 1);
      wait_done(1'b0, 1'b0, dcyc);
      chk("parity_beats", q.size(), 0);
      chk("sticky_set", err_sticky, 1);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
